// File: rtl/dk_pkg.sv
// Shared definitions for the Donkey Kong datapath.
//   - game_state_e : game-flow state encoding driven on game_ctrl.game_state
//   - KEY_*        : bit indices into the 5-bit keydown bus
//   - board limits : coordinate widths and visible playfield extents
//   - SCORE_MAX    : score saturation value
package dk_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_READY   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_DYING   = 3'd3,
        ST_WIN     = 3'd4,
        ST_OVER    = 3'd5
    } game_state_e;

    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_LEFT  = 1;
    localparam int unsigned KEY_RIGHT = 2;
    localparam int unsigned KEY_DOWN  = 3;
    localparam int unsigned KEY_JUMP  = 4;
    localparam int unsigned KEY_W     = 5;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;
    localparam logic [X_W-1:0] BOARD_X_MAX = 10'd639;
    localparam logic [Y_W-1:0] BOARD_Y_MAX = 9'd479;

    localparam logic [19:0] SCORE_MAX = 20'd999_999;

endpackage

// File: rtl/hit_box.sv
// Combinational axis-aligned overlap check between two objects.
// Ports:
//   ax, ay  : position of object A
//   bx, by  : position of object B
//   overlap : |ax-bx| < 2*HIT_W and |ay-by| < 2*HIT_H
// Differences are unsigned absolute values, so coordinates never wrap.
module hit_box
    import dk_pkg::*;
#(
    parameter int unsigned HIT_W = 12,
    parameter int unsigned HIT_H = 14
) (
    input  logic [X_W-1:0] ax,
    input  logic [Y_W-1:0] ay,
    input  logic [X_W-1:0] bx,
    input  logic [Y_W-1:0] by,
    output logic           overlap
);

    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    always_comb begin
        dx      = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy      = (ay >= by) ? (ay - by) : (by - ay);
        overlap = (32'(dx) < 2 * HIT_W) && (32'(dy) < 2 * HIT_H);
    end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow sequencer: attract, ready countdown, play, death, win, game over.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   frame_tick          : one-cycle pulse per video frame; all updates gated by it
//   keydown[4:0]        : key levels (see dk_pkg KEY_*)
//   mario_x/y           : Mario position
//   hazard_valid/x/y    : active hazard and its position
//   mario_rst/start/over: control levels to the mario block
//   game_state          : current dk_pkg::game_state_e value
//   lives, score, bonus : HUD values (score saturates at 999_999)
module game_ctrl
    import dk_pkg::*;
#(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned READY_FRAMES = 90,
    parameter int unsigned DIE_FRAMES   = 64,
    parameter int unsigned WIN_FRAMES   = 120,
    parameter int unsigned TIME_DIV     = 60,
    parameter int unsigned BONUS_INIT   = 5000,
    parameter int unsigned HIT_W        = 12,
    parameter int unsigned HIT_H        = 14,
    parameter logic [8:0]  GOAL_Y       = 9'd50,
    parameter logic [9:0]  GOAL_X0      = 10'd250,
    parameter logic [9:0]  GOAL_X1      = 10'd390
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [4:0]  keydown,
    input  logic [9:0]  mario_x,
    input  logic [8:0]  mario_y,
    input  logic        hazard_valid,
    input  logic [9:0]  hazard_x,
    input  logic [8:0]  hazard_y,
    output logic        mario_rst,
    output logic        mario_start,
    output logic        mario_over,
    output logic [2:0]  game_state,
    output logic [2:0]  lives,
    output logic [19:0] score,
    output logic [13:0] bonus
);

    game_state_e state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [2:0]  lives_q, lives_d;
    logic [19:0] score_q, score_d;
    logic [13:0] bonus_q, bonus_d;
    logic        key_prev_q, key_prev_d;
    logic        mario_rst_q, mario_rst_d;
    logic        mario_start_q, mario_start_d;
    logic        mario_over_q, mario_over_d;

    logic        overlap;
    logic        hit;
    logic        goal;
    logic        key_any;
    logic        key_press;
    logic [20:0] score_sum;

    hit_box #(
        .HIT_W (HIT_W),
        .HIT_H (HIT_H)
    ) u_hit_box (
        .ax      (mario_x),
        .ay      (mario_y),
        .bx      (hazard_x),
        .by      (hazard_y),
        .overlap (overlap)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        div_cnt_d   = div_cnt_q;
        lives_d     = lives_q;
        score_d     = score_q;
        bonus_d     = bonus_q;
        key_prev_d  = key_prev_q;
        score_sum   = '0;

        key_any   = |keydown;
        key_press = key_any & ~key_prev_q;
        hit       = hazard_valid & overlap;
        goal      = (mario_y <= GOAL_Y) && (mario_x >= GOAL_X0) && (mario_x <= GOAL_X1);

        if (frame_tick) begin
            key_prev_d  = key_any;
            frame_cnt_d = frame_cnt_q + 8'd1;
            unique case (state_q)
                ST_ATTRACT: if (key_press) state_d = ST_READY;
                ST_READY: begin
                    if (frame_cnt_q == 8'(READY_FRAMES - 1)) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (div_cnt_q == 8'(TIME_DIV - 1)) begin
                        div_cnt_d = '0;
                        bonus_d   = (bonus_q >= 14'd100) ? (bonus_q - 14'd100) : '0;
                    end else begin
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                    // Score uses the post-decrement bonus, so a goal on the
                    // tick the bonus runs out awards nothing.
                    score_sum = {1'b0, score_q} + 21'(bonus_d);
                    if (hit) begin
                        state_d = ST_DYING;
                    end else if (goal) begin
                        state_d = ST_WIN;
                        score_d = (score_sum > 21'(SCORE_MAX)) ? SCORE_MAX : score_sum[19:0];
                    end else if (bonus_d == '0) begin
                        state_d = ST_DYING;
                    end
                end
                ST_DYING: begin
                    if (frame_cnt_q == 8'(DIE_FRAMES - 1)) begin
                        if (lives_q == 3'd1) begin
                            lives_d = '0;
                            state_d = ST_OVER;
                        end else begin
                            lives_d = lives_q - 3'd1;
                            state_d = ST_READY;
                        end
                    end
                end
                ST_WIN: begin
                    if (frame_cnt_q == 8'(WIN_FRAMES - 1)) state_d = ST_READY;
                end
                ST_OVER: begin
                    if (key_press) begin
                        state_d = ST_ATTRACT;
                        lives_d = 3'(LIVES);
                        score_d = '0;
                    end
                end
                default: state_d = ST_ATTRACT;
            endcase

            if (state_d != state_q) begin
                frame_cnt_d = '0;
                div_cnt_d   = '0;
                if (state_d == ST_READY) bonus_d = 14'(BONUS_INIT);
            end
        end

        // Control levels are decoded from the next state so they change in
        // the same cycle as game_state.
        mario_rst_d   = (state_d == ST_ATTRACT) || (state_d == ST_READY) || (state_d == ST_OVER);
        mario_start_d = (state_d == ST_PLAY) || (state_d == ST_DYING);
        mario_over_d  = (state_d == ST_DYING);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_ATTRACT;
            frame_cnt_q   <= '0;
            div_cnt_q     <= '0;
            lives_q       <= 3'(LIVES);
            score_q       <= '0;
            bonus_q       <= '0;
            key_prev_q    <= 1'b1;
            mario_rst_q   <= 1'b1;
            mario_start_q <= 1'b0;
            mario_over_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            div_cnt_q     <= div_cnt_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            bonus_q       <= bonus_d;
            key_prev_q    <= key_prev_d;
            mario_rst_q   <= mario_rst_d;
            mario_start_q <= mario_start_d;
            mario_over_q  <= mario_over_d;
        end
    end

    assign game_state  = state_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign bonus       = bonus_q;
    assign mario_rst   = mario_rst_q;
    assign mario_start = mario_start_q;
    assign mario_over  = mario_over_q;

endmodule
